// File: rtl/mbcd2binary_if.sv
// rtl/mbcd2binary_if.sv - request/result bundle for the BCD-to-binary converter
//
// Signals:
//   start  request a conversion (driven by master)
//   bcd    packed BCD digits, most significant digit in the MSBs (driven by master)
//   bin    binary result (driven by slave)
//   busy   conversion in progress (driven by slave)
//   done   one-cycle result-valid pulse (driven by slave)
//   err    last conversion saw a digit > 9 (driven by slave)
// Modports: master (requester), slave (converter).

interface mbcd2binary_if #(
    parameter int DIGITS = 3,
    parameter int BW     = 10
);
    logic                  start;
    logic [4*DIGITS-1:0]   bcd;
    logic [BW-1:0]         bin;
    logic                  busy;
    logic                  done;
    logic                  err;

    modport master (
        output start,
        output bcd,
        input  bin,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  start,
        input  bcd,
        output bin,
        output busy,
        output done,
        output err
    );
endinterface

// File: rtl/mbcd2binary.sv
// rtl/mbcd2binary.sv - sequential BCD-to-binary converter (reverse double-dabble)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  synchronous active-low reset
//   bus    mbcd2binary_if.slave: start/bcd in, bin/busy/done/err out
//
// Parameters:
//   DIGITS  number of BCD input digits
//   BW      binary result width and number of shift iterations
//           (must cover 10**DIGITS - 1)
//
// Optional feature macro: MBCD2BINARY_DIGIT_CHECK_EN
//   defined     - a start with any digit > 9 completes in one cycle with
//                 bin=0, err=1
//   undefined   - no digit check, err is tied low, every start runs the
//                 full BW-shift path

module mbcd2binary #(
    parameter int DIGITS = 3,
    parameter int BW     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    mbcd2binary_if.slave     bus
);

    localparam int WW = 4 * DIGITS + BW;
    localparam int CW = $clog2(BW + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WW-1:0]    work;
    logic [WW-1:0]    work_next;
    logic [CW-1:0]    cnt;
    logic [BW-1:0]    bin_r;
    logic             busy_r;
    logic             done_r;

    // One reverse double-dabble step: shift right, then pull every BCD
    // field that reached 8 or more back by 3. A field >= 8 after the shift
    // means a bit of weight 10 crossed into a weight-16 position, and
    // 16/2 - 10/2 = 3 corrects it.
    function automatic logic [WW-1:0] dabble_step(input logic [WW-1:0] w);
        logic [WW-1:0] s;
        s = w >> 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (s[BW + 4*i +: 4] >= 4'd8) begin
                s[BW + 4*i +: 4] = s[BW + 4*i +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

`ifdef MBCD2BINARY_DIGIT_CHECK_EN
    logic err_r;

    function automatic logic has_bad_digit(input logic [4*DIGITS-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    assign bus.err = err_r;
`else
    assign bus.err = 1'b0;
`endif

    always_comb begin
        work_next = dabble_step(work);
    end

    assign bus.bin  = bin_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            work   <= '0;
            cnt    <= '0;
            bin_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
`ifdef MBCD2BINARY_DIGIT_CHECK_EN
            err_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
`ifdef MBCD2BINARY_DIGIT_CHECK_EN
                        if (has_bad_digit(bus.bcd)) begin
                            // Invalid input short-circuits straight to DONE.
                            bin_r  <= '0;
                            err_r  <= 1'b1;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end else begin
                            err_r  <= 1'b0;
`else
                        begin
`endif
                            work   <= {bus.bcd, {BW{1'b0}}};
                            cnt    <= '0;
                            busy_r <= 1'b1;
                            state  <= SHIFT;
                        end
                    end
                end

                SHIFT: begin
                    work <= work_next;
                    cnt  <= cnt + CW'(1);
                    // cnt counts completed shifts, so BW-1 here means this
                    // edge performs the final one; take the result from the
                    // freshly shifted value rather than the registered one.
                    if (cnt == CW'(BW - 1)) begin
                        bin_r  <= work_next[BW-1:0];
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end

                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end

                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mbcd2binary.sv
// tb/tb_mbcd2binary.sv - directed self-checking bench for mbcd2binary

module tb_mbcd2binary;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    mbcd2binary_if #(.DIGITS(3), .BW(10)) bus ();

    mbcd2binary #(.DIGITS(3), .BW(10)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_bad  = 0;
    int overlap = 0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.busy === 1'b1 && bus.done === 1'b1) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raises start for one edge (edge index 0), then waits for done.
    // lat is the index of the edge that raised done (-1 on timeout);
    // b1 is busy sampled just after the start edge.
    task automatic start_and_wait(input logic [11:0] v, output int lat, output logic b1);
        lat = -1;
        b1  = 1'b0;
        bus.start = 1'b1;
        bus.bcd   = v;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 0) begin
                bus.start = 1'b0;
                bus.bcd   = 12'h000;
                b1 = bus.busy;
            end
            if (bus.done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic run_conv(input string tag, input logic [11:0] v, input bit chk_bin,
                            input logic [9:0] exp_bin, input int exp_lat, input logic exp_err);
        int   lat;
        logic b1;
        start_and_wait(v, lat, b1);
        check($sformatf("%s_done_edge", tag), lat, exp_lat);
        if (chk_bin) check($sformatf("%s_bin", tag), bus.bin, exp_bin);
        check($sformatf("%s_err", tag), bus.err, exp_err);
        check($sformatf("%s_busy_at_done", tag), bus.busy, 0);
        if (exp_lat > 0) check($sformatf("%s_busy_after_start", tag), b1, 1);
        tick();
        check($sformatf("%s_done_one_cycle", tag), bus.done, 0);
    endtask

    initial begin
        int   pulses;
        int   lat;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.bcd   = 12'h000;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_bin",  bus.bin,  0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_err",  bus.err,  0);

        run_conv("zero", 12'h000, 1'b1, 10'd0,   10, 1'b0);
        run_conv("b999", 12'h999, 1'b1, 10'd999, 10, 1'b0);
        run_conv("b075", 12'h075, 1'b1, 10'd75,  10, 1'b0);
        run_conv("b128", 12'h128, 1'b1, 10'd128, 10, 1'b0);

`ifdef MBCD2BINARY_DIGIT_CHECK_EN
        // Bad digit: done is raised by the start edge itself.
        run_conv("bad12a", 12'h12A, 1'b1, 10'd0, 0, 1'b1);
        run_conv("b041",   12'h041, 1'b1, 10'd41, 10, 1'b0);
`else
        run_conv("nochk12a", 12'h12A, 1'b0, 10'd0, 10, 1'b0);
        run_conv("b041",     12'h041, 1'b1, 10'd41, 10, 1'b0);
`endif

        // A second start mid-conversion must be ignored.
        pulses = 0;
        lat    = -1;
        bus.start = 1'b1;
        bus.bcd   = 12'h063;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (c == 0) begin
                bus.start = 1'b0;
                bus.bcd   = 12'h000;
            end
            if (c == 3) begin
                bus.start = 1'b1;
                bus.bcd   = 12'h500;
            end
            if (c == 4) begin
                bus.start = 1'b0;
                bus.bcd   = 12'h000;
            end
            if (bus.done === 1'b1) begin
                pulses++;
                if (lat < 0) lat = c;
            end
        end
        check("ign_done_edge", lat, 10);
        check("ign_pulses", pulses, 1);
        check("ign_bin", bus.bin, 63);
        check("ign_busy", bus.busy, 0);

        // Reset in the middle of a conversion aborts it.
        bus.start = 1'b1;
        bus.bcd   = 12'h250;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 0) begin
                bus.start = 1'b0;
                bus.bcd   = 12'h000;
            end
        end
        check("abort_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        tick();
        check("abort_bin",  bus.bin,  0);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_err",  bus.err,  0);
        rst_n = 1'b1;
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        check("abort_no_done", pulses, 0);
        run_conv("b250", 12'h250, 1'b1, 10'd250, 10, 1'b0);

        check("busy_done_overlap", overlap, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mbcd2binary.md
Name: mbcd2binary

Overview:
- Sequential BCD-to-binary converter; inverse of the combinational binary-to-BCD block (Mbinary2BCD).
- Accepts DIGITS packed BCD digits on a start pulse and returns the unsigned binary value after a fixed multi-cycle latency.
- Uses reverse double-dabble: shift right, then subtract 3 from every BCD digit that is >= 8.
- Used as the back-conversion path and as a self-check partner for the BCD encoder.

Parameters:
- DIGITS, 3, number of BCD input digits.
- BW, 10, binary result width and shift-iteration count. BW must be >= ceil(log2(10^DIGITS)); 10 for 3 digits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request conversion; sampled only in IDLE.
- bcd  input  4*DIGITS  packed digits; most significant digit in the MSBs (bcd[11:8]=hundreds, [7:4]=tens, [3:0]=units).
- bin  output  BW  binary result; holds until the next accepted conversion.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse: result valid.
- err  output  1  last conversion had an invalid digit (>9); holds like bin.

Behaviour:
- Reset (rst_n=0 at a clock edge) gives state=IDLE, bin=0, busy=0, done=0, err=0, and clears internal registers.
- Reset wins over every other input. Asserting reset mid-conversion aborts it: no done pulse, and bin/err are cleared.
- States are IDLE, SHIFT, DONE.
- IDLE, start=1 at edge E0:
  - Any digit > 9: go to DONE, bin=0, err=1, done=1 after E0. Error latency is 1 cycle.
  - Otherwise: load a (4*DIGITS+BW)-bit work register as {bcd, BW'b0}, iteration counter=0, busy=1, err=0, go to SHIFT.
- SHIFT, each edge:
  - Logical-shift the work register right by 1.
  - Then, for each 4-bit digit field of the shifted upper part, subtract 3 if the field is >= 8.
  - Increment the counter.
  - On the BW-th shift edge (E_BW): load bin from the low BW bits of the work register, set busy=0 and done=1, go to DONE.
- DONE, next edge: done=0, go to IDLE. bin and err hold.
- Latency: done is high during the cycle after E_BW, which is 10 cycles after the start edge for defaults. Back-to-back throughput is one conversion per BW+2 cycles.
- start while busy or in DONE is ignored: no queuing, and the in-flight result is unaffected.
- bcd only needs to be stable at the start edge; it is captured there.
- Result range is 0..10^DIGITS-1, so bin never overflows for valid input.
- busy and done are never high in the same cycle.

Optional Feature:
- Macro MBCD2BINARY_DIGIT_CHECK_EN.
- Defined: invalid-digit detection exactly as described above (err path, 1-cycle error completion).
- Not defined:
  - No digit check; err is tied to 0.
  - Every accepted start takes the full BW-shift path.
  - Digits > 9 are processed by the same shift/subtract algorithm. bin is whatever the algorithm yields, with no error indication.
  - Latency is identical to the valid case.

Test Plan:
- Reset held 3 cycles, then released -> bin=0, busy=0, done=0, err=0.
- start with bcd=12'h000 -> busy for 10 cycles, done pulse, bin=10'd0, err=0.
- bcd=12'h999 -> done exactly 10 cycles after the start edge, bin=10'd999 (10'h3E7). Then bcd=12'h075 -> bin=75; bcd=12'h128 -> bin=128.
- bcd=12'h12A (macro defined) -> done after 1 cycle, err=1, bin=0. The next valid start (12'h041) clears err and gives bin=41.
- During a 12'h063 conversion, pulse start with 12'h500 at cycle 4 -> ignored; result bin=63, one done pulse only.
- Assert rst_n=0 at cycle 5 of a 12'h250 conversion -> no done pulse, outputs 0. A new start with 12'h250 gives bin=250.
